rx_decim_model: RTL

RX_DECIM_MODEL -- requirements
Module: rx_decim_model

---
 rtl/rx_decim_model.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rx_decim_model.sv
// Multi-channel RX decimator: per-window sample-or-accumulate, channel serializer
// and a first-word-fall-through output FIFO with a sticky overflow flag.
module rx_decim_model #(
    parameter int N_CH    = 2,
    parameter int IW      = 16,
    parameter int CW      = 12,
    parameter int FIFO_AW = 4,
    localparam int UW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            rate_axis_tdata_i,
    input  logic                   rate_axis_tvalid_i,
    input  logic                   mode_i,
    input  logic [N_CH*2*IW-1:0]   rx_iq_axis_tdata_i,
    input  logic                   rx_iq_axis_tvalid_i,
    input  logic                   axis_tready_i,
    output logic                   axis_tvalid_o,
    output logic [63:0]            axis_tdata_o,
    output logic [UW-1:0]          axis_tuser_o,
    input  logic                   clear_ovf_i,
    output logic                   overflow_o,
    output logic                   ser_busy_dbg
);

    // Output handshake: a word transfers on a rising edge where axis_tvalid_o and
    // axis_tready_i are both high; the head word holds steady until it transfers.

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNTW  = FIFO_AW + 1;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

    typedef enum logic {SER_IDLE, SER_RUN} ser_state_t;

    logic [CW-1:0]   rate_q;
    logic [CW-1:0]   cnt;
    logic [31:0]     acc_i [N_CH];
    logic [31:0]     acc_q [N_CH];
    logic [IW-1:0]   smp_i [N_CH];
    logic [IW-1:0]   smp_q [N_CH];
    logic [63:0]     win_word [N_CH];
    logic [63:0]     hold [N_CH];
    logic            win_end;
    logic            accept;
    logic            win_drop;
    logic            unused_rate_bits;

    ser_state_t      ser_state, ser_next;
    logic [UW-1:0]   ser_ch, ser_ch_next;
    logic            ser_last;

    logic [64+UW-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            push_req, push_ok, push_drop, pop, full;

    assign unused_rate_bits = ^rate_axis_tdata_i[15:CW];

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            smp_i[c] = rx_iq_axis_tdata_i[c*2*IW +: IW];
            smp_q[c] = rx_iq_axis_tdata_i[c*2*IW+IW +: IW];
        end
    end

    // A rate load takes priority: any sample in the same cycle never counts.
    assign win_end = rx_iq_axis_tvalid_i && !rate_axis_tvalid_i && (cnt == rate_q - CW'(1));

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            if (mode_i) begin
                win_word[c] = {acc_q[c] + {{(32-IW){smp_q[c][IW-1]}}, smp_q[c]},
                               acc_i[c] + {{(32-IW){smp_i[c][IW-1]}}, smp_i[c]}};
            end else begin
                win_word[c] = {smp_q[c], {(32-IW){1'b0}}, smp_i[c], {(32-IW){1'b0}}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_q <= CW'(1);
            cnt    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                acc_i[c] <= '0;
                acc_q[c] <= '0;
            end
        end else if (rate_axis_tvalid_i) begin
            rate_q <= (rate_axis_tdata_i[CW-1:0] == '0) ? CW'(1) : rate_axis_tdata_i[CW-1:0];
            cnt    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                acc_i[c] <= '0;
                acc_q[c] <= '0;
            end
        end else if (rx_iq_axis_tvalid_i) begin
            cnt <= win_end ? '0 : cnt + CW'(1);
            for (int c = 0; c < N_CH; c++) begin
                if (win_end) begin
                    acc_i[c] <= '0;
                    acc_q[c] <= '0;
                end else begin
                    acc_i[c] <= acc_i[c] + {{(32-IW){smp_i[c][IW-1]}}, smp_i[c]};
                    acc_q[c] <= acc_q[c] + {{(32-IW){smp_q[c][IW-1]}}, smp_q[c]};
                end
            end
        end
    end

    // The serializer's final push cycle can already take a new window.
    assign ser_last = (ser_ch == UW'(N_CH-1));
    assign accept   = win_end && (ser_state == SER_IDLE || ser_last);
    assign win_drop = win_end && !accept;
    assign ser_busy_dbg = (ser_state == SER_RUN);

    always_comb begin
        ser_next    = ser_state;
        ser_ch_next = ser_ch;
        case (ser_state)
            SER_IDLE: begin
                if (accept) begin
                    ser_next    = SER_RUN;
                    ser_ch_next = '0;
                end
            end
            SER_RUN: begin
                if (ser_last) begin
                    if (accept) ser_ch_next = '0;
                    else        ser_next    = SER_IDLE;
                end else begin
                    ser_ch_next = ser_ch + UW'(1);
                end
            end
            default: ser_next = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_state <= SER_IDLE;
            ser_ch    <= '0;
            for (int c = 0; c < N_CH; c++) hold[c] <= '0;
        end else begin
            ser_state <= ser_next;
            ser_ch    <= ser_ch_next;
            if (accept) begin
                for (int c = 0; c < N_CH; c++) hold[c] <= win_word[c];
            end
        end
    end

    assign push_req  = (ser_state == SER_RUN);
    assign full      = (count == DEPTH_C);
    assign pop       = (count != '0) && axis_tready_i;
    assign push_ok   = push_req && (!full || pop);
    assign push_drop = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {ser_ch, hold[ser_ch]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Gating on occupancy keeps the outputs zero while empty, including in reset.
    assign axis_tvalid_o = (count != '0);
    assign axis_tdata_o  = axis_tvalid_o ? mem[rd_ptr][63:0] : 64'd0;
    assign axis_tuser_o  = axis_tvalid_o ? mem[rd_ptr][64 +: UW] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       overflow_o <= 1'b0;
        else if (win_drop || push_drop)   overflow_o <= 1'b1;
        else if (clear_ovf_i)             overflow_o <= 1'b0;
    end

endmodule
